tree_operand_feeder: RTL and testbench

//  Producer side of the 32-input signed tree adder. On a start pulse it issues 32 reads
//  (data and coefficient memories in parallel) and multiplies each signed pair. Each
//  36-bit product is stored in slot k. When all 32 slots hold the new job's products,
//  the flat slot bus is presented to the adder under a valid/ack handshake.

---
 rtl/tree_operand_feeder_pkg.sv | 34 +++
 rtl/tree_operand_feeder_slot_bank.sv | 30 +++
 rtl/tree_operand_feeder.sv | 95 +++++++++
 tb/tb_tree_operand_feeder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_operand_feeder_pkg.sv
// Shared widths, slot count and FSM encodings for the tree-adder operand feeder.
// Also holds the signed multiply helper used when a fetched pair is captured.
package tree_operand_feeder_pkg;
  localparam int N_TAPS = 32;
  localparam int IDX_W  = 5;
  localparam int DATA_W = 16;
  localparam int COEF_W = 20;
  localparam int PROD_W = DATA_W + COEF_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_DRAIN = ST_DRAIN,
    S_HOLD  = ST_HOLD
  } state_e;

  // Sign-extend both operands to the product width; the low PROD_W bits of
  // that product are exactly the full signed result.
  function automatic logic [PROD_W-1:0] mul_signed(input logic [DATA_W-1:0] a,
                                                   input logic [COEF_W-1:0] b);
    logic [PROD_W-1:0] ax;
    logic [PROD_W-1:0] bx;
    logic [PROD_W-1:0] p;
    ax = {{COEF_W{a[DATA_W-1]}}, a};
    bx = {{DATA_W{b[COEF_W-1]}}, b};
    p  = ax * bx;
    return p;
  endfunction
endpackage

// File: rtl/tree_operand_feeder_slot_bank.sv
// 32 x 36-bit product register file with one write port and a flat read bus.
// Every slot is visible at once so the adder can consume them in parallel.
module feeder_slot_bank
  import tree_operand_feeder_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [IDX_W-1:0]         widx,
  input  logic [PROD_W-1:0]        wdata,
  output logic [N_TAPS*PROD_W-1:0] rd_flat
);
  genvar gi;
  for (gi = 0; gi < N_TAPS; gi++) begin : g_slot
    logic [PROD_W-1:0] slot_q;
    logic [PROD_W-1:0] slot_d;

    always_comb begin
      slot_d = slot_q;
      if (we && (widx == IDX_W'(gi))) slot_d = wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) slot_q <= '0;
      else        slot_q <= slot_d;
    end

    assign rd_flat[gi*PROD_W +: PROD_W] = slot_q;
  end
endmodule

// File: rtl/tree_operand_feeder.sv
// Fetches 32 data/coefficient pairs, multiplies each pair into its slot and
// presents the full slot bus to the tree adder under a valid/ack handshake.
module tree_operand_feeder
  import tree_operand_feeder_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        data_base,
  input  logic [ADDR_W-1:0]        coef_base,
  input  logic                     stall,
  output logic                     mem_rd,
  output logic [ADDR_W-1:0]        data_addr,
  output logic [ADDR_W-1:0]        coef_addr,
  input  logic [DATA_W-1:0]        data_q,
  input  logic [COEF_W-1:0]        coef_q,
  output logic [N_TAPS*PROD_W-1:0] prod_flat,
  output logic                     prod_valid,
  input  logic                     prod_ack,
  output logic                     busy
);
  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  widx_q, widx_d;
  logic [ADDR_W-1:0] data_base_q, data_base_d;
  logic [ADDR_W-1:0] coef_base_q, coef_base_d;
  logic              rd_dly_q, rd_dly_d;
  logic              issue;

  assign issue = (state_q == S_FETCH) && !stall;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    data_base_d = data_base_q;
    coef_base_d = coef_base_q;
    rd_dly_d    = issue;
    widx_d      = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_FETCH;
          idx_d       = '0;
          data_base_d = data_base;
          coef_base_d = coef_base;
        end
      end
      S_FETCH: begin
        if (issue) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(N_TAPS - 1)) state_d = S_DRAIN;
        end
      end
      // One cycle for the final SRAM word to arrive and be multiplied.
      S_DRAIN: state_d = S_HOLD;
      S_HOLD:  if (prod_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      widx_q      <= '0;
      data_base_q <= '0;
      coef_base_q <= '0;
      rd_dly_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      widx_q      <= widx_d;
      data_base_q <= data_base_d;
      coef_base_q <= coef_base_d;
      rd_dly_q    <= rd_dly_d;
    end
  end

  assign mem_rd     = issue;
  assign data_addr  = data_base_q + ADDR_W'(idx_q);
  assign coef_addr  = coef_base_q + ADDR_W'(idx_q);
  assign prod_valid = (state_q == S_HOLD);
  assign busy       = (state_q != S_IDLE);

  feeder_slot_bank u_slots (
    .clk     (clk),
    .reset   (reset),
    .we      (rd_dly_q),
    .widx    (widx_q),
    .wdata   (mul_signed(data_q, coef_q)),
    .rd_flat (prod_flat)
  );
endmodule

// File: tb/tb_tree_operand_feeder.sv
// Directed bench for tree_operand_feeder with a 1-cycle-latency SRAM model.
// Each scenario task drives its own stimulus and checks against hand-derived values.
module tb_tree_operand_feeder;
  localparam int PW = 36;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [11:0]       data_base;
  logic [11:0]       coef_base;
  logic              stall;
  logic              mem_rd;
  logic [11:0]       data_addr;
  logic [11:0]       coef_addr;
  logic [15:0]       data_q;
  logic [19:0]       coef_q;
  logic [32*PW-1:0]  prod_flat;
  logic              prod_valid;
  logic              prod_ack;
  logic              busy;

  logic [15:0] dmem [4096];
  logic [19:0] cmem [4096];
  logic [11:0] dlog [32];
  logic [11:0] clog [32];

  int total = 0;
  int bad   = 0;

  tree_operand_feeder dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .data_base  (data_base),
    .coef_base  (coef_base),
    .stall      (stall),
    .mem_rd     (mem_rd),
    .data_addr  (data_addr),
    .coef_addr  (coef_addr),
    .data_q     (data_q),
    .coef_q     (coef_q),
    .prod_flat  (prod_flat),
    .prod_valid (prod_valid),
    .prod_ack   (prod_ack),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) begin
      data_q <= dmem[data_addr];
      coef_q <= cmem[coef_addr];
    end
  end

  // Starts a job and steps cycles; c counts cycles after the start cycle T.
  task automatic run_job(input logic [11:0] db, input logic [11:0] cb,
                         input int st_lo, input int st_hi, input int abort_at,
                         output int lat, output int nrd);
    lat = -1;
    nrd = 0;
    data_base = db;
    coef_base = cb;
    start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      stall = (c >= st_lo) && (c <= st_hi);
      #1;
      if (prod_valid) begin
        lat = c;
        break;
      end
      if (mem_rd) begin
        if (nrd < 32) begin
          dlog[nrd] = data_addr;
          clog[nrd] = coef_addr;
        end
        nrd++;
      end
      if (c == abort_at) break;
    end
    stall = 1'b0;
  endtask

  task automatic ack_job();
    prod_ack = 1'b1;
    @(posedge clk); #1;
    prod_ack = 1'b0;
  endtask

  task automatic fill_ramp(input logic [11:0] db, input logic [11:0] cb);
    for (int k = 0; k < 32; k++) begin
      dmem[db + 12'(k)] = 16'(k + 1);
      cmem[cb + 12'(k)] = 20'd2;
    end
  endtask

  task automatic test_reset();
    total++;
    if ({mem_rd, data_addr, coef_addr, prod_valid, busy} !== 27'd0 || prod_flat !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rd=%0b da=%h ca=%h pv=%0b busy=%0b flat_zero=%0b, need all 0",
               mem_rd, data_addr, coef_addr, prod_valid, busy, prod_flat == '0);
    end else $display("reset_outputs ok");
  endtask

  task automatic test_ramp();
    int lat, nrd, errs;
    longint sum;
    fill_ramp(12'h100, 12'h200);
    run_job(12'h100, 12'h200, 0, -1, 0, lat, nrd);
    total++;
    if (lat !== 34) begin bad++; $display("FAIL ramp_latency: got %0d need 34", lat); end
    else $display("ramp_latency ok (34)");
    errs = 0;
    sum = 0;
    for (int k = 0; k < 32; k++) begin
      sum += longint'($signed(prod_flat[k*PW +: PW]));
      if (prod_flat[k*PW +: PW] !== 36'(2*(k+1))) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL ramp_slots: got %0d wrong slots need 0", errs); end
    else $display("ramp_slots ok");
    total++;
    if (sum != 1056) begin bad++; $display("FAIL ramp_sum: got %0d need 1056", sum); end
    else $display("ramp_sum ok (1056)");
    ack_job();
  endtask

  task automatic test_extremes();
    int lat, nrd;
    logic signed [35:0] s2;
    for (int k = 0; k < 32; k++) begin
      dmem[12'h300 + 12'(k)] = 16'd0;
      cmem[12'h400 + 12'(k)] = 20'd0;
    end
    dmem[12'h300] = 16'h8000;  cmem[12'h400] = 20'h80000;
    dmem[12'h301] = 16'hFFFF;  cmem[12'h401] = 20'h00001;
    dmem[12'h302] = 16'd100;   cmem[12'h402] = 20'hFFFF9;
    run_job(12'h300, 12'h400, 0, -1, 0, lat, nrd);
    total++;
    if (prod_flat[0 +: PW] !== 36'h4_0000_0000) begin
      bad++; $display("FAIL ext_min_min: got %h need 400000000", prod_flat[0 +: PW]);
    end else $display("ext_min_min ok");
    total++;
    if (prod_flat[PW +: PW] !== 36'hF_FFFF_FFFF) begin
      bad++; $display("FAIL ext_neg_one: got %h need fffffffff", prod_flat[PW +: PW]);
    end else $display("ext_neg_one ok");
    s2 = prod_flat[2*PW +: PW];
    total++;
    if (s2 !== -36'sd700) begin bad++; $display("FAIL ext_mixed: got %0d need -700", s2); end
    else $display("ext_mixed ok");
    ack_job();
  endtask

  task automatic test_stall();
    int lat, nrd, errs;
    fill_ramp(12'h100, 12'h200);
    run_job(12'h100, 12'h200, 12, 16, 0, lat, nrd);
    total++;
    if (lat !== 39) begin bad++; $display("FAIL stall_latency: got %0d need 39", lat); end
    else $display("stall_latency ok (39)");
    total++;
    if (nrd !== 32) begin bad++; $display("FAIL stall_reads: got %0d need 32", nrd); end
    else $display("stall_reads ok");
    errs = 0;
    for (int k = 0; k < 32; k++) begin
      if (prod_flat[k*PW +: PW] !== 36'(2*(k+1))) errs++;
      if (dlog[k] !== 12'h100 + 12'(k)) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL stall_slots: got %0d errors need 0", errs); end
    else $display("stall_slots ok");
  endtask

  // Entered with the previous job still in HOLD.
  task automatic test_hold();
    logic [32*PW-1:0] snap;
    int errs;
    snap = prod_flat;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      start = i[0];
      @(posedge clk); #1;
      if (prod_flat !== snap || prod_valid !== 1'b1 || busy !== 1'b1) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL hold_stable: got %0d bad cycles need 0", errs); end
    else $display("hold_stable ok");
    start = 1'b1;
    prod_ack = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    prod_ack = 1'b0;
    total++;
    if (prod_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL hold_release: got pv=%0b busy=%0b need 0 0", prod_valid, busy);
    end else $display("hold_release ok");
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL hold_no_restart: got busy=%0b need 0", busy); end
    else $display("hold_no_restart ok");
  endtask

  task automatic test_wrap();
    int lat, nrd, errs;
    run_job(12'hFFE, 12'h7F0, 0, -1, 0, lat, nrd);
    errs = 0;
    for (int i = 0; i < 32; i++) begin
      if (dlog[i] !== 12'hFFE + 12'(i)) errs++;
      if (clog[i] !== 12'h7F0 + 12'(i)) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL wrap_addrs: got %0d wrong need 0", errs); end
    else $display("wrap_addrs ok (0xFFE..0x01D)");
    total++;
    if (dlog[2] !== 12'h000) begin bad++; $display("FAIL wrap_third: got %h need 000", dlog[2]); end
    else $display("wrap_third ok");
    ack_job();
  endtask

  task automatic test_abort();
    int lat, nrd, errs;
    run_job(12'h300, 12'h400, 0, -1, 18, lat, nrd);
    total++;
    if (busy !== 1'b1 || data_addr !== 12'h311) begin
      bad++; $display("FAIL abort_setup: got busy=%0b da=%h need 1 311", busy, data_addr);
    end else $display("abort_setup ok");
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({mem_rd, data_addr, coef_addr, prod_valid, busy} !== 27'd0 || prod_flat !== '0) begin
      bad++;
      $display("FAIL abort_clear: got rd=%0b da=%h ca=%h pv=%0b busy=%0b flat_zero=%0b, need all 0",
               mem_rd, data_addr, coef_addr, prod_valid, busy, prod_flat == '0);
    end else $display("abort_clear ok");
    reset = 1'b1;
    @(posedge clk); #1;
    fill_ramp(12'h100, 12'h200);
    run_job(12'h100, 12'h200, 0, -1, 0, lat, nrd);
    errs = 0;
    for (int k = 0; k < 32; k++)
      if (prod_flat[k*PW +: PW] !== 36'(2*(k+1))) errs++;
    total++;
    if (lat !== 34 || errs != 0) begin
      bad++; $display("FAIL abort_rerun: got lat=%0d wrong=%0d need 34 0", lat, errs);
    end else $display("abort_rerun ok");
    ack_job();
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    data_base = '0;
    coef_base = '0;
    stall = 1'b0;
    prod_ack = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      dmem[i] = '0;
      cmem[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    test_ramp();
    test_extremes();
    test_stall();
    test_hold();
    test_wrap();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
